// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//
// Purpose:
//   An instruction memory that software or a boot engine fills in bursts, and
//   that the core then reads with single-cycle latency. The controller has
//   three states:
//     IDLE - after reset; nothing is loaded or fetched.
//     LOAD - accepts a burst of words written from address 0 upward.
//     RUN  - serves fetches, one per cycle.
//   Memory contents are not cleared by reset. A reset in the middle of a load
//   aborts the burst and keeps the words already written.
//
// Optional feature (macro INST_PARITY_EN):
//   When defined, one even-parity bit is stored with every word and checked on
//   every fetch. A mismatch raises ParityErr alongside InstValid. When it is
//   not defined, no parity storage exists and ParityErr is tied to 0.
//
// Parameters:
//   A - instruction address width (depth = 2**A words)
//   W - instruction word width
//
// Ports:
//   Clk          in   single clock, rising edge
//   Reset_n      in   synchronous active-low reset
//   LoadStart    in   begin a load burst (taken in IDLE or RUN, ignored in LOAD)
//   LoadValid    in   LoadData holds a word
//   LoadData     in   word to write            [W-1:0]
//   LoadLast     in   final word of the burst
//   LoadReady    out  block is accepting load words (high throughout LOAD)
//   LoadDone     out  one-cycle pulse on the first RUN cycle after a load
//   FetchReq     in   fetch request (honoured in RUN only)
//   InstAddress  in   fetch address            [A-1:0]
//   InstOut      out  fetched word, held between fetches   [W-1:0]
//   InstValid    out  InstOut was updated this cycle
//   ParityErr    out  parity mismatch on the fetch completing this cycle
//   state_dbg    out  current controller state (0=IDLE, 1=LOAD, 2=RUN)
//
// Load handshake: a word is transferred on every rising edge where both
// LoadValid and LoadReady are high. LoadValid low is a stall with no write.
// LoadReady does not depend on LoadValid. The burst ends on the transfer that
// carries LoadLast, or on the transfer that writes the top address.
// ---------------------------------------------------------------------------
module inst_rom_loader #(
  parameter int A = 8,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         LoadStart,
  input  logic         LoadValid,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadReady,
  output logic         LoadDone,
  input  logic         FetchReq,
  input  logic [A-1:0] InstAddress,
  output logic [W-1:0] InstOut,
  output logic         InstValid,
  output logic         ParityErr,
  output logic [1:0]   state_dbg
);

  localparam int DEPTH = 1 << A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [A-1:0] ptr;
  logic [W-1:0] mem [DEPTH];
  logic         load_fire;
  logic         load_end;
  logic         fetch_fire;
  logic         done_q;
  logic [W-1:0] inst_q;
  logic         valid_q;
  logic         par_err_q;

  // A transfer happens whenever the block is in LOAD and data is offered.
  assign load_fire  = (state == S_LOAD) && LoadValid;
  assign load_end   = load_fire && (LoadLast || (ptr == {A{1'b1}}));
  // A load request arriving in RUN takes priority and drops the fetch.
  assign fetch_fire = (state == S_RUN) && FetchReq && !LoadStart;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (LoadStart) state_nxt = S_LOAD;
      S_LOAD:  if (load_end)  state_nxt = S_RUN;
      S_RUN:   if (LoadStart) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    LoadReady = (state == S_LOAD);
    LoadDone  = done_q;
    InstOut   = inst_q;
    InstValid = valid_q;
`ifdef INST_PARITY_EN
    ParityErr = par_err_q;
`else
    ParityErr = 1'b0;
`endif
    state_dbg = state;
  end

  // -------------------------------------------------------------------------
  // Write pointer and completion pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      // done_q is high only during the cycle right after the final transfer.
      done_q <= load_end;
      if ((state != S_LOAD) && LoadStart) begin
        ptr <= '0;
      end else if (load_fire && (ptr != {A{1'b1}})) begin
        // Holding at the top address keeps the pointer from wrapping; the
        // burst has ended by then anyway.
        ptr <= ptr + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage (never reset). The write is blocked during the reset cycle so
  // that a reset mid-burst cannot sneak one more word in.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset_n && load_fire) begin
      mem[ptr] <= LoadData;
    end
  end

`ifdef INST_PARITY_EN
  logic par_mem [DEPTH];

  // Even parity: the stored bit makes the total count of ones even.
  always_ff @(posedge Clk) begin
    if (Reset_n && load_fire) begin
      par_mem[ptr] <= ^LoadData;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Fetch path: one-cycle latency, one fetch per cycle
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      inst_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      valid_q <= fetch_fire;
      if (fetch_fire) begin
        inst_q <= mem[InstAddress];
      end
`ifdef INST_PARITY_EN
      // With the stored bit included, an odd count of ones means corruption.
      par_err_q <= fetch_fire && (^{mem[InstAddress], par_mem[InstAddress]});
`else
      par_err_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_loader
//
// Self-checking bench for inst_rom_loader with A=4, W=9. Inputs are driven
// 1 time unit after the rising edge and outputs are sampled 1 time unit after
// the next rising edge. A simple array model holds what memory should contain;
// fetched words are predicted into an expected queue and popped on return.
// ---------------------------------------------------------------------------
module tb_inst_rom_loader;

  localparam int A = 4;
  localparam int W = 9;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
`ifdef INST_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic         load_start;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_last;
  logic         load_ready;
  logic         load_done;
  logic         fetch_req;
  logic [A-1:0] inst_address;
  logic [W-1:0] inst_out;
  logic         inst_valid;
  logic         parity_err;
  logic [1:0]   state_dbg;

  inst_rom_loader #(.A(A), .W(W)) dut (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .LoadStart   (load_start),
    .LoadValid   (load_valid),
    .LoadData    (load_data),
    .LoadLast    (load_last),
    .LoadReady   (load_ready),
    .LoadDone    (load_done),
    .FetchReq    (fetch_req),
    .InstAddress (inst_address),
    .InstOut     (inst_out),
    .InstValid   (inst_valid),
    .ParityErr   (parity_err),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model and scoreboard state
  // ---------------------------------------------------------------------------
  int           n_checks;
  int           n_pass;
  logic [W-1:0] model_mem [16];
  logic [W-1:0] load_words [16];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_out;

  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] exp;
  } fetch_vec_t;

  fetch_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Words come from load_words[0..n-1]; the burst must end by LoadLast or at
  // the top address. An optional stall of stall_len cycles precedes word
  // stall_at, during which a fetch is attempted and must be ignored.
  task automatic load_body(input int n, input bit use_last, input int stall_at, input int stall_len);
    bit ends;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          load_valid = 1'b0;
          fetch_req = 1'b1;
          inst_address = 4'(i);
          tick();
          check("stall_ready", 32'(load_ready), 32'd1);
          check("stall_no_fetch", 32'(inst_valid), 32'd0);
          check("stall_state", 32'(state_dbg), 32'(ST_LOAD));
        end
        fetch_req = 1'b0;
      end
      load_valid = 1'b1;
      load_data = load_words[i];
      load_last = use_last && (i == n - 1);
      tick();
      model_mem[i] = load_words[i];
      ends = (use_last && (i == n - 1)) || (i == 15);
      if (ends) begin
        check("end_state", 32'(state_dbg), 32'(ST_RUN));
        check("end_done", 32'(load_done), 32'd1);
        check("end_ready", 32'(load_ready), 32'd0);
      end else begin
        check("mid_state", 32'(state_dbg), 32'(ST_LOAD));
        check("mid_done", 32'(load_done), 32'd0);
      end
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    tick();
    check("done_one_cycle", 32'(load_done), 32'd0);
  endtask

  task automatic load_burst(input int n, input bit use_last, input int stall_at, input int stall_len);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_state", 32'(state_dbg), 32'(ST_LOAD));
    check("start_ready", 32'(load_ready), 32'd1);
    load_body(n, use_last, stall_at, stall_len);
  endtask

  task automatic run_fetch(input int addr, input bit req, input bit exp_perr);
    logic [W-1:0] exp;
    fetch_req = req;
    inst_address = 4'(addr);
    if (req) exp_q.push_back(model_mem[addr]);
    tick();
    if (req) begin
      exp = exp_q.pop_front();
      last_out = exp;
      check("fetch_valid", 32'(inst_valid), 32'd1);
      check("fetch_data", 32'(inst_out), 32'(exp));
      check("fetch_parity", 32'(parity_err), 32'(exp_perr));
    end else begin
      check("hold_valid", 32'(inst_valid), 32'd0);
      check("hold_data", 32'(inst_out), 32'(last_out));
      check("hold_parity", 32'(parity_err), 32'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_pass = 0;
    last_out = '0;
    reset_n = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    fetch_req = 1'b0;
    inst_address = '0;

    vecs[0] = '{addr: 4'd2, exp: 9'h13C};
    vecs[1] = '{addr: 4'd0, exp: 9'h1A5};
    vecs[2] = '{addr: 4'd3, exp: 9'h007};
    vecs[3] = '{addr: 4'd1, exp: 9'h0F0};

    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_out", 32'(inst_out), 32'd0);
    check("rst_parity", 32'(parity_err), 32'd0);
    reset_n = 1'b1;

    // Fetch in IDLE is ignored
    fetch_req = 1'b1;
    inst_address = 4'd3;
    tick();
    fetch_req = 1'b0;
    check("idle_fetch_valid", 32'(inst_valid), 32'd0);
    check("idle_fetch_out", 32'(inst_out), 32'd0);
    check("idle_state", 32'(state_dbg), 32'(ST_IDLE));

    // Four-word burst ended by LoadLast, then table-driven read-back
    load_words[0] = 9'h1A5;
    load_words[1] = 9'h0F0;
    load_words[2] = 9'h13C;
    load_words[3] = 9'h007;
    load_burst(4, 1'b1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1;
      inst_address = vecs[i].addr;
      tick();
      check("vec_valid", 32'(inst_valid), 32'd1);
      check("vec_data", 32'(inst_out), 32'(vecs[i].exp));
      last_out = vecs[i].exp;
    end
    run_fetch(0, 1'b0, 1'b0);

    // Sixteen-word burst without LoadLast, 3-cycle stall mid-burst
    for (int i = 0; i < 16; i++) load_words[i] = 9'(16'h0101 * i + 16'h0033);
    load_burst(16, 1'b0, 8, 3);
    for (int i = 0; i < 16; i++) run_fetch(i, 1'b1, 1'b0);
    run_fetch(0, 1'b0, 1'b0);

    // Reset after two words aborts the load but keeps written words
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 9'h055;
    tick();
    load_data = 9'h0AA;
    tick();
    model_mem[0] = 9'h055;
    model_mem[1] = 9'h0AA;
    load_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_ready", 32'(load_ready), 32'd0);
    check("abort_done", 32'(load_done), 32'd0);
    reset_n = 1'b1;
    last_out = '0;
    tick();
    check("abort_done_after", 32'(load_done), 32'd0);
    load_words[0] = 9'h1F0;
    load_burst(1, 1'b1, -1, 0);
    run_fetch(0, 1'b1, 1'b0);
    run_fetch(1, 1'b1, 1'b0);
    run_fetch(2, 1'b1, 1'b0);

    // LoadStart and FetchReq together in RUN
    load_start = 1'b1;
    fetch_req = 1'b1;
    inst_address = 4'd4;
    tick();
    load_start = 1'b0;
    fetch_req = 1'b0;
    check("collide_state", 32'(state_dbg), 32'(ST_LOAD));
    check("collide_valid", 32'(inst_valid), 32'd0);
    check("collide_out", 32'(inst_out), 32'(last_out));
    load_words[0] = 9'h0C3;
    load_words[1] = 9'h13A;
    load_body(2, 1'b1, 1, 2);
    run_fetch(1, 1'b1, 1'b0);
    run_fetch(0, 1'b1, 1'b0);

    // Randomized bursts and fetch streams
    for (int it = 0; it < 6; it++) begin
      int n;
      bit ul;
      n = int'($urandom_range(1, 16));
      ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) load_words[i] = 9'($urandom_range(0, 511));
      load_burst(n, ul, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 3)));
      for (int k = 0; k < 16; k++) begin
        run_fetch(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // Full reload, then corrupt parity at address 5 when the feature exists
    for (int i = 0; i < 16; i++) load_words[i] = 9'($urandom_range(0, 511));
    load_burst(16, 1'b0, -1, 0);
`ifdef INST_PARITY_EN
    dut.par_mem[5] = ~dut.par_mem[5];
`endif
    for (int i = 0; i < 16; i++) run_fetch(i, 1'b1, PAR_EN && (i == 5));
    run_fetch(3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL have parameter A, default 8: instruction address width; depth is 2**A words.
REQ-002 SHALL have parameter W, default 9: instruction word width.
REQ-003 SHALL have Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have Reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have LoadStart  input  1  request to begin a load burst.
REQ-006 SHALL have LoadValid  input  1  LoadData holds a valid word.
REQ-007 SHALL have LoadData  input  W  word to write.
REQ-008 SHALL have LoadLast  input  1  marks the final word of a burst.
REQ-009 SHALL have LoadReady  output  1  block accepts load words.
REQ-010 SHALL have LoadDone  output  1  one-cycle pulse at load completion.
REQ-011 SHALL have FetchReq  input  1  fetch request.
REQ-012 SHALL have InstAddress  input  A  fetch address.
REQ-013 SHALL have InstOut  output  W  fetched instruction word.
REQ-014 SHALL have InstValid  output  1  InstOut was updated this cycle.
REQ-015 SHALL have ParityErr  output  1  parity mismatch on a fetch (see Configuration).

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD and RUN.
REQ-017 SHALL, in IDLE or RUN, go to LOAD on LoadStart and clear the write pointer to 0.
REQ-018 SHALL, in LOAD, drive LoadReady=1; LoadStart SHALL be ignored.
REQ-019 SHALL, on each cycle with LoadValid&LoadReady, write LoadData to mem[ptr] and increment ptr; a cycle without LoadValid SHALL be a stall with no write.
REQ-020 SHALL go LOAD->RUN after an accepted word with LoadLast=1, or after an accepted write to address 2**A-1; ptr SHALL NOT wrap.
REQ-021 SHALL assert LoadDone for exactly the first cycle in RUN after a load.
REQ-022 SHALL, in RUN only, sample InstAddress on FetchReq and present mem[InstAddress] on InstOut with InstValid=1 on the next cycle (1-cycle latency, one fetch per cycle, full throughput).
REQ-023 SHALL ignore FetchReq in IDLE and LOAD; InstValid SHALL be 0 on the following cycle.
REQ-024 SHALL hold InstOut at its last value when no fetch completes; InstValid=0 in those cycles.
REQ-025 SHALL, when LoadStart and FetchReq coincide in RUN, enter LOAD and drop the fetch; InstValid=0 on the following cycle.
REQ-026 SHALL, for fetches of never-written addresses, return undefined data with InstValid=1.

Reset
REQ-027 SHALL, on Reset_n=0 at a clock edge, set state=IDLE, ptr=0, LoadReady=0, LoadDone=0, InstValid=0, InstOut=0, ParityErr=0.
REQ-028 SHALL NOT clear memory contents on reset; reset mid-load SHALL abort the load (no LoadDone) and keep the words already written.

Configuration
REQ-029 SHALL, with INST_PARITY_EN defined, store one even-parity bit per word on write, recompute it on fetch and drive ParityErr=1 alongside InstValid on a mismatch.
REQ-030 SHALL, without INST_PARITY_EN, omit the parity storage and tie ParityErr to 0.

Verification (A=4, W=9)
REQ-031 SHALL check: reset, then FetchReq in IDLE -> InstValid=0; InstOut=0.
REQ-032 SHALL check: load 9'h1A5, 9'h0F0, 9'h13C, 9'h007 with LoadLast on the 4th -> LoadDone pulse in the next cycle, then fetch addr 2 -> InstOut=9'h13C, InstValid=1 one cycle later.
REQ-033 SHALL check: 16-word load without LoadLast, with LoadValid low for 3 cycles mid-burst -> RUN entered after the addr-15 write; all 16 words read back at one fetch per cycle.
REQ-034 SHALL check: Reset_n=0 after 2 words -> IDLE, LoadReady=0, no LoadDone; a new load then writes from addr 0.
REQ-035 SHALL check: LoadStart and FetchReq in the same RUN cycle -> LOAD entered, InstValid=0 next cycle.
REQ-036 SHALL check: with INST_PARITY_EN, a stored parity bit forced wrong at addr 5 -> fetch addr 5 gives ParityErr=1; all other addresses give ParityErr=0.
